// File: rtl/dice_pkg.sv
// Shared types and constants for the dice roll checker.
// Faces are coded 1..6; statistic select codes 0 and 7 pick the invalid and repeat counters.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    localparam logic [2:0] FACE_MIN       = 3'd1;
    localparam logic [2:0] FACE_MAX       = 3'd6;
    localparam logic [2:0] RD_SEL_INVALID = 3'd0;
    localparam logic [2:0] RD_SEL_REPEAT  = 3'd7;

    // Any code with bits 6:3 set, or 0 / 7, is not a legal face.
    function automatic logic is_face(input logic [6:0] code);
        return (code >= 7'(FACE_MIN)) && (code <= 7'(FACE_MAX));
    endfunction

endpackage

// File: rtl/dice_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module dice_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/dice_roll_checker.sv
// Collects WINDOW dice rolls into face/invalid/repeat statistics and reports
// whether the face histogram spread stays within TOL.
//
//   state   | meaning
//   IDLE    | waiting for start; counters hold last window's results
//   COLLECT | accepting rolls until WINDOW have been taken
//   REPORT  | one-cycle done pulse; fairness result is latched
module dice_roll_checker
    import dice_pkg::*;
#(
    parameter int WINDOW = 60,
    parameter int CNT_W  = 8,
    parameter int TOL    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             roll_valid,
    input  logic [6:0]       roll_code,
    output logic             roll_ready,
    output logic             busy,
    output logic             done,
    input  logic [2:0]       rd_sel,
    output logic [CNT_W-1:0] rd_data,
    output logic [2:0]       last_face,
    output logic             err,
    output logic             uniform_ok
);

    localparam int IDX_W = $clog2(WINDOW + 1);

    state_t            state, state_nx;
    logic              accept;
    logic              clr;
    logic              code_ok;
    logic [2:0]        face;
    logic [7:0]        inc;
    logic [CNT_W-1:0]  cnt [8];
    logic [IDX_W-1:0]  rolls_left;
    logic              last_roll;
    logic [CNT_W-1:0]  cnt_max, cnt_min, spread;
    logic              fair;
    logic              uok_q;

    assign code_ok   = is_face(roll_code);
    assign face      = roll_code[2:0];
    assign accept    = roll_valid & roll_ready;
    assign last_roll = accept && (rolls_left == IDX_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        roll_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        clr        = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr      = 1'b1;
                    state_nx = COLLECT;
                end
            end
            COLLECT: begin
                roll_ready = 1'b1;
                busy       = 1'b1;
                if (last_roll) begin
                    state_nx = REPORT;
                end
            end
            REPORT: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Remaining-roll down-counter; the accept that finds 1 left ends the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rolls_left <= '0;
        end else if (clr) begin
            rolls_left <= IDX_W'(WINDOW);
        end else if (accept) begin
            rolls_left <= rolls_left - 1'b1;
        end
    end

    always_comb begin
        inc                 = '0;
        inc[RD_SEL_INVALID] = accept & ~code_ok;
        for (int f = int'(FACE_MIN); f <= int'(FACE_MAX); f++) begin
            inc[f] = accept & code_ok & (face == 3'(f));
        end
        inc[RD_SEL_REPEAT]  = accept & code_ok & (last_face != 3'd0) & (face == last_face);
    end

    for (genvar i = 0; i < 8; i++) begin : g_cnt
        dice_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .inc   (inc[i]),
            .count (cnt[i])
        );
    end

    assign rd_data = cnt[rd_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_face <= 3'd0;
            err       <= 1'b0;
        end else if (clr) begin
            last_face <= 3'd0;
            err       <= 1'b0;
        end else if (accept) begin
            if (code_ok) begin
                last_face <= face;
            end else begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        cnt_max = cnt[FACE_MIN];
        cnt_min = cnt[FACE_MIN];
        for (int f = int'(FACE_MIN) + 1; f <= int'(FACE_MAX); f++) begin
            if (cnt[f] > cnt_max) cnt_max = cnt[f];
            if (cnt[f] < cnt_min) cnt_min = cnt[f];
        end
    end

    assign spread = cnt_max - cnt_min;
    assign fair   = 32'(spread) <= 32'(TOL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uok_q <= 1'b0;
        end else if (clr) begin
            uok_q <= 1'b0;
        end else if (state == REPORT) begin
            uok_q <= fair;
        end
    end

    // Counters are frozen in REPORT, so the live result is already final during done.
    assign uniform_ok = (state == REPORT) ? fair : uok_q;

endmodule

// File: tb/tb_dice_roll_checker.sv
// Four checker instances with different WINDOW/CNT_W/TOL share one stimulus stream;
// each is compared against a behavioural histogram model every cycle.
`timescale 1ns/1ps
module tb_dice_roll_checker;

    localparam int NI = 4;
    localparam int WIN [NI] = '{6, 4, 3, 20};
    localparam int CW  [NI] = '{8, 8, 8, 4};
    localparam int TL  [NI] = '{4, 2, 4, 4};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       roll_valid = 1'b0;
    logic [6:0] roll_code = 7'd0;
    logic [2:0] rd_sel = 3'd0;

    logic       rr_o [NI];
    logic       bz_o [NI];
    logic       dn_o [NI];
    logic       er_o [NI];
    logic       uo_o [NI];
    logic [2:0] lf_o [NI];
    logic [7:0] rd_o [NI];

    always #10 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic            rr_l, bz_l, dn_l, er_l, uo_l;
        logic [2:0]      lf_l;
        logic [CW[g]-1:0] rd_l;
        dice_roll_checker #(.WINDOW(WIN[g]), .CNT_W(CW[g]), .TOL(TL[g])) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (start),
            .roll_valid (roll_valid),
            .roll_code  (roll_code),
            .roll_ready (rr_l),
            .busy       (bz_l),
            .done       (dn_l),
            .rd_sel     (rd_sel),
            .rd_data    (rd_l),
            .last_face  (lf_l),
            .err        (er_l),
            .uniform_ok (uo_l)
        );
        assign rr_o[g] = rr_l;
        assign bz_o[g] = bz_l;
        assign dn_o[g] = dn_l;
        assign er_o[g] = er_l;
        assign uo_o[g] = uo_l;
        assign lf_o[g] = lf_l;
        assign rd_o[g] = 8'(rd_l);
    end

    // Behavioural model: phase 0 idle, 1 collecting, 2 reporting.
    int m_phase [NI];
    int m_cnt   [NI][8];
    int m_last  [NI];
    int m_err   [NI];
    int m_uok   [NI];
    int m_taken [NI];

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model_fair(input int g);
        int mx, mn;
        mx = m_cnt[g][1];
        mn = m_cnt[g][1];
        for (int f = 2; f <= 6; f++) begin
            if (m_cnt[g][f] > mx) mx = m_cnt[g][f];
            if (m_cnt[g][f] < mn) mn = m_cnt[g][f];
        end
        return ((mx - mn) <= TL[g]) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int g = 0; g < NI; g++) begin
            m_phase[g] = 0;
            m_last[g]  = 0;
            m_err[g]   = 0;
            m_uok[g]   = 0;
            m_taken[g] = 0;
            for (int s = 0; s < 8; s++) m_cnt[g][s] = 0;
        end
    endtask

    task automatic bump(input int g, input int s);
        if (m_cnt[g][s] < (1 << CW[g]) - 1) m_cnt[g][s]++;
    endtask

    task automatic model_step(input logic st, input logic rv, input logic [6:0] code);
        int c;
        c = int'(code);
        for (int g = 0; g < NI; g++) begin
            case (m_phase[g])
                0: if (st) begin
                    for (int s = 0; s < 8; s++) m_cnt[g][s] = 0;
                    m_last[g]  = 0;
                    m_err[g]   = 0;
                    m_uok[g]   = 0;
                    m_taken[g] = 0;
                    m_phase[g] = 1;
                end
                1: if (rv) begin
                    if (c >= 1 && c <= 6) begin
                        bump(g, c);
                        if (m_last[g] != 0 && m_last[g] == c) bump(g, 7);
                        m_last[g] = c;
                    end else begin
                        bump(g, 0);
                        m_err[g] = 1;
                    end
                    m_taken[g]++;
                    if (m_taken[g] == WIN[g]) m_phase[g] = 2;
                end
                default: begin
                    m_uok[g]   = model_fair(g);
                    m_phase[g] = 0;
                end
            endcase
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < NI; g++) begin
            chk($sformatf("i%0d roll_ready", g), 32'(rr_o[g]), 32'(m_phase[g] == 1));
            chk($sformatf("i%0d busy", g),       32'(bz_o[g]), 32'(m_phase[g] == 1));
            chk($sformatf("i%0d done", g),       32'(dn_o[g]), 32'(m_phase[g] == 2));
            chk($sformatf("i%0d last_face", g),  32'(lf_o[g]), 32'(m_last[g]));
            chk($sformatf("i%0d err", g),        32'(er_o[g]), 32'(m_err[g]));
            chk($sformatf("i%0d uniform_ok", g), 32'(uo_o[g]),
                32'((m_phase[g] == 2) ? model_fair(g) : m_uok[g]));
        end
        for (int s = 0; s < 8; s++) begin
            rd_sel = 3'(s);
            #0.5;
            for (int g = 0; g < NI; g++) begin
                chk($sformatf("i%0d rd_data[%0d]", g, s), 32'(rd_o[g]), 32'(m_cnt[g][s]));
            end
        end
    endtask

    // Inputs are applied before the edge, the model steps on it, outputs are checked 1 ns later.
    task automatic tick(input logic st, input logic rv, input logic [6:0] code);
        start      = st;
        roll_valid = rv;
        roll_code  = code;
        @(posedge clk);
        model_step(st, rv, code);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        start      = 1'b0;
        roll_valid = 1'b0;
        rst        = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        rst = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input int g, input int sel, input int exp);
        rd_sel = 3'(sel);
        #0.5;
        chk(nm, 32'(rd_o[g]), 32'(exp));
    endtask

    typedef struct {
        logic       st;
        logic       rv;
        logic [6:0] code;
        logic       e_ready;
        logic       e_busy;
        logic       e_done;
        logic       e_uok;
        logic [2:0] e_last;
    } vec_t;

    vec_t tbl [8];

    typedef struct {
        logic       st;
        logic       rv;
        logic [6:0] code;
        logic       e_done;
    } gap_t;

    gap_t gaps [10];

    initial begin
        // Instance 0 (WINDOW=6): one of each face back-to-back.
        tbl[0] = '{1'b1, 1'b0, 7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0};
        tbl[1] = '{1'b0, 1'b1, 7'd1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1};
        tbl[2] = '{1'b0, 1'b1, 7'd2, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2};
        tbl[3] = '{1'b0, 1'b1, 7'd3, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3};
        tbl[4] = '{1'b0, 1'b1, 7'd4, 1'b1, 1'b1, 1'b0, 1'b0, 3'd4};
        tbl[5] = '{1'b0, 1'b1, 7'd5, 1'b1, 1'b1, 1'b0, 1'b0, 3'd5};
        tbl[6] = '{1'b0, 1'b1, 7'd6, 1'b0, 1'b0, 1'b1, 1'b1, 3'd6};
        tbl[7] = '{1'b0, 1'b0, 7'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd6};

        // Instance 0: gaps and start pulses; six accepts at rows 0,2,4,5,7,8.
        gaps[0] = '{1'b0, 1'b1, 7'd2, 1'b0};
        gaps[1] = '{1'b1, 1'b0, 7'd3, 1'b0};
        gaps[2] = '{1'b0, 1'b1, 7'd4, 1'b0};
        gaps[3] = '{1'b0, 1'b0, 7'd3, 1'b0};
        gaps[4] = '{1'b0, 1'b1, 7'd2, 1'b0};
        gaps[5] = '{1'b1, 1'b1, 7'd4, 1'b0};
        gaps[6] = '{1'b0, 1'b0, 7'd3, 1'b0};
        gaps[7] = '{1'b0, 1'b1, 7'd4, 1'b0};
        gaps[8] = '{1'b0, 1'b1, 7'd2, 1'b1};
        gaps[9] = '{1'b0, 1'b0, 7'd3, 1'b0};

        model_reset();
        do_reset();
        chk("reset roll_ready", 32'(rr_o[0]), 32'd0);
        chk("reset uniform_ok", 32'(uo_o[0]), 32'd0);

        for (int i = 0; i < 8; i++) begin
            tick(tbl[i].st, tbl[i].rv, tbl[i].code);
            chk($sformatf("tbl%0d ready", i), 32'(rr_o[0]), 32'(tbl[i].e_ready));
            chk($sformatf("tbl%0d busy", i),  32'(bz_o[0]), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d done", i),  32'(dn_o[0]), 32'(tbl[i].e_done));
            chk($sformatf("tbl%0d uok", i),   32'(uo_o[0]), 32'(tbl[i].e_uok));
            chk($sformatf("tbl%0d last", i),  32'(lf_o[0]), 32'(tbl[i].e_last));
        end
        for (int f = 1; f <= 6; f++) rd_chk($sformatf("w6 face%0d", f), 0, f, 1);
        rd_chk("w6 repeat", 0, 7, 0);
        rd_chk("w6 invalid", 0, 0, 0);

        // Instance 1 (WINDOW=4, TOL=2): 3,3,3,5.
        do_reset();
        tick(1'b1, 1'b0, 7'd0);
        tick(1'b0, 1'b1, 7'd3);
        tick(1'b0, 1'b1, 7'd3);
        tick(1'b0, 1'b1, 7'd3);
        tick(1'b0, 1'b1, 7'd5);
        chk("w4 done", 32'(dn_o[1]), 32'd1);
        chk("w4 uniform_ok", 32'(uo_o[1]), 32'd0);
        chk("w4 last_face", 32'(lf_o[1]), 32'd5);
        rd_chk("w4 face3", 1, 3, 3);
        rd_chk("w4 face5", 1, 5, 1);
        rd_chk("w4 repeat", 1, 7, 2);

        // Instance 2 (WINDOW=3): two invalid codes then face 2.
        do_reset();
        tick(1'b1, 1'b0, 7'd0);
        tick(1'b0, 1'b1, 7'd0);
        tick(1'b0, 1'b1, 7'h41);
        tick(1'b0, 1'b1, 7'd2);
        chk("w3 done", 32'(dn_o[2]), 32'd1);
        chk("w3 err", 32'(er_o[2]), 32'd1);
        chk("w3 last_face", 32'(lf_o[2]), 32'd2);
        rd_chk("w3 invalid", 2, 0, 2);
        rd_chk("w3 face2", 2, 2, 1);
        rd_chk("w3 repeat", 2, 7, 0);

        // Instance 3 (CNT_W=4, WINDOW=20): twenty 5s saturate.
        do_reset();
        tick(1'b1, 1'b0, 7'd0);
        for (int i = 0; i < 19; i++) tick(1'b0, 1'b1, 7'd5);
        chk("w20 not done early", 32'(dn_o[3]), 32'd0);
        tick(1'b0, 1'b1, 7'd5);
        chk("w20 done", 32'(dn_o[3]), 32'd1);
        rd_chk("w20 face5 sat", 3, 5, 15);
        rd_chk("w20 repeat sat", 3, 7, 15);

        // Reset mid-window, then roll_valid without start.
        do_reset();
        tick(1'b1, 1'b0, 7'd0);
        tick(1'b0, 1'b1, 7'd1);
        tick(1'b0, 1'b1, 7'd2);
        tick(1'b0, 1'b1, 7'd3);
        rst = 1'b1;
        #1;
        chk("async rst busy", 32'(bz_o[0]), 32'd0);
        chk("async rst ready", 32'(rr_o[0]), 32'd0);
        chk("async rst last", 32'(lf_o[0]), 32'd0);
        do_reset();
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 7'd4);
        chk("no start ready", 32'(rr_o[0]), 32'd0);
        rd_chk("no start face4", 0, 4, 0);

        // Gapped rolls with ignored start pulses on instance 0.
        do_reset();
        tick(1'b1, 1'b0, 7'd0);
        for (int i = 0; i < 10; i++) begin
            tick(gaps[i].st, gaps[i].rv, gaps[i].code);
            chk($sformatf("gap%0d done", i), 32'(dn_o[0]), 32'(gaps[i].e_done));
        end
        rd_chk("gap face2", 0, 2, 3);
        rd_chk("gap face4", 0, 4, 3);
        rd_chk("gap face3", 0, 3, 0);
        rd_chk("gap repeat", 0, 7, 1);
        chk("gap uniform_ok", 32'(uo_o[0]), 32'd1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic       st, rv;
            logic [6:0] code;
            if ($urandom_range(199) == 0) begin
                do_reset();
            end else begin
                st = ($urandom_range(7) == 0);
                rv = ($urandom_range(3) != 0);
                if ($urandom_range(9) < 8) code = 7'($urandom_range(6, 1));
                else code = 7'($urandom);
                tick(st, rv, code);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
